// File: rtl/rfdc_pkg.sv
// Shared types and default widths for the RFDC burst sequencer.
package rfdc_pkg;

   localparam int BEAT_W_DEF = 16;
   localparam int REP_W_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/rfdc_burst_sequencer.sv
// Gates a sine sample source into repeated bursts of handshaked beats separated by idle gaps.
// Handshake: a beat transfers on a cycle where src_tvalid and src_tready are both high.
module rfdc_burst_sequencer
   import rfdc_pkg::*;
#(
   parameter int BEAT_W = BEAT_W_DEF,
   parameter int REP_W  = REP_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [BEAT_W-1:0] cfg_burst_beats,
   input  logic [BEAT_W-1:0] cfg_gap_cycles,
   input  logic [REP_W-1:0]  cfg_repeat,
   output logic              src_enable,
   input  logic              src_tvalid,
   input  logic              src_tready,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic [REP_W-1:0]  burst_idx
);

   state_t            state, state_nxt;
   logic [BEAT_W-1:0] cnt, cnt_nxt;
   logic [BEAT_W-1:0] lat_beats, lat_beats_nxt;
   logic [BEAT_W-1:0] lat_gap, lat_gap_nxt;
   logic [REP_W-1:0]  lat_rep, lat_rep_nxt;
   logic [REP_W-1:0]  idx_nxt;
   logic              cfg_err_nxt;
   logic              beat_hs;
   logic              last_burst;

   assign beat_hs    = src_tvalid & src_tready;
   assign last_burst = (lat_rep != '0) && (burst_idx == lat_rep - REP_W'(1));

   // Outputs decode the registered state only, so there is no input-to-output path.
   assign src_enable = (state == ST_BURST);
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         lat_beats <= '0;
         lat_gap   <= '0;
         lat_rep   <= '0;
         burst_idx <= '0;
         cfg_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         lat_beats <= lat_beats_nxt;
         lat_gap   <= lat_gap_nxt;
         lat_rep   <= lat_rep_nxt;
         burst_idx <= idx_nxt;
         cfg_err   <= cfg_err_nxt;
      end
   end

   // One counter serves both as the beat count in BURST and the cycle count in GAP.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      lat_beats_nxt = lat_beats;
      lat_gap_nxt   = lat_gap;
      lat_rep_nxt   = lat_rep;
      idx_nxt       = burst_idx;
      cfg_err_nxt   = 1'b0;

      if (state != ST_IDLE && abort) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  if (cfg_burst_beats == '0) begin
                     cfg_err_nxt = 1'b1;
                  end else begin
                     lat_beats_nxt = cfg_burst_beats;
                     lat_gap_nxt   = cfg_gap_cycles;
                     lat_rep_nxt   = cfg_repeat;
                     cnt_nxt       = '0;
                     idx_nxt       = '0;
                     state_nxt     = ST_BURST;
                  end
               end
            end
            ST_BURST: begin
               if (beat_hs) begin
                  if (cnt == lat_beats - BEAT_W'(1)) begin
                     cnt_nxt = '0;
                     if (last_burst) begin
                        state_nxt = ST_DONE;
                     end else if (lat_gap != '0) begin
                        state_nxt = ST_GAP;
                     end else begin
                        idx_nxt = burst_idx + REP_W'(1);
                     end
                  end else begin
                     cnt_nxt = cnt + BEAT_W'(1);
                  end
               end
            end
            ST_GAP: begin
               if (cnt == lat_gap - BEAT_W'(1)) begin
                  cnt_nxt   = '0;
                  idx_nxt   = burst_idx + REP_W'(1);
                  state_nxt = ST_BURST;
               end else begin
                  cnt_nxt = cnt + BEAT_W'(1);
               end
            end
            ST_DONE: begin
               state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rfdc_burst_sequencer.sv
// Directed bench for rfdc_burst_sequencer: inputs change and outputs are sampled on the falling edge.
module tb_rfdc_burst_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] cfg_burst_beats;
   logic [15:0] cfg_gap_cycles;
   logic [7:0]  cfg_repeat;
   logic        src_enable;
   logic        src_tvalid;
   logic        src_tready;
   logic        busy;
   logic        done;
   logic        cfg_err;
   logic [7:0]  burst_idx;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rfdc_burst_sequencer #(.BEAT_W(16), .REP_W(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .abort           (abort),
      .cfg_burst_beats (cfg_burst_beats),
      .cfg_gap_cycles  (cfg_gap_cycles),
      .cfg_repeat      (cfg_repeat),
      .src_enable      (src_enable),
      .src_tvalid      (src_tvalid),
      .src_tready      (src_tready),
      .busy            (busy),
      .done            (done),
      .cfg_err         (cfg_err),
      .burst_idx       (burst_idx)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves the bench at the falling edge inside the first BURST cycle.
   task automatic cfg_start(input int beats, input int gap, input int rep);
      cfg_burst_beats = 16'(beats);
      cfg_gap_cycles  = 16'(gap);
      cfg_repeat      = 8'(rep);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   logic [11:0] exp_en1;

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_burst_beats = '0; cfg_gap_cycles = '0; cfg_repeat = '0;
      src_tvalid = 1'b1; src_tready = 1'b1;
      #3;
      check("rst_en", src_enable, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", cfg_err, 0);
      check("rst_idx", burst_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // burst=4 gap=2 repeat=2; a mid-sequence start with new config must be ignored
      exp_en1 = 12'b1111_0011_1100;
      cfg_start(4, 2, 2);
      for (int i = 0; i < 12; i++) begin
         check($sformatf("t1_en_%0d", i), src_enable, exp_en1[11-i]);
         check($sformatf("t1_done_%0d", i), done, (i == 10));
         check($sformatf("t1_busy_%0d", i), busy, (i < 11));
         if (i == 1) begin
            start = 1'b1; cfg_burst_beats = 16'd7; cfg_gap_cycles = 16'd5;
         end
         if (i == 2) start = 1'b0;
         @(negedge clk);
      end

      // burst=3 gap=0 repeat=3: nine back-to-back enable cycles
      cfg_start(3, 0, 3);
      for (int i = 0; i < 11; i++) begin
         check($sformatf("t2_en_%0d", i), src_enable, (i < 9));
         if (i < 9) check($sformatf("t2_idx_%0d", i), burst_idx, i / 3);
         check($sformatf("t2_done_%0d", i), done, (i == 9));
         @(negedge clk);
      end
      check("t2_busy_end", busy, 0);

      // burst=4 with tready low on even cycles: handshakes on cycles 1,3,5,7
      cfg_start(4, 0, 1);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("t3_en_%0d", i), src_enable, (i < 8));
         check($sformatf("t3_done_%0d", i), done, (i == 8));
         src_tready = (i % 2 == 1);
         @(negedge clk);
      end
      src_tready = 1'b1;

      // zero-length burst is rejected
      cfg_burst_beats = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t4_err_pulse", cfg_err, 1);
      check("t4_busy", busy, 0);
      @(negedge clk);
      check("t4_err_clear", cfg_err, 0);
      check("t4_busy2", busy, 0);

      // abort together with start in IDLE wins
      cfg_burst_beats = 16'd4; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("t5_abort_start_busy", busy, 0);
      check("t5_abort_start_en", src_enable, 0);

      // burst=2 gap=3 repeat=5, abort in second GAP cycle
      cfg_start(2, 3, 5);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t6_en_%0d", i), src_enable, (i < 2));
         check($sformatf("t6_busy_%0d", i), busy, 1);
         if (i == 3) abort = 1'b1;
         @(negedge clk);
      end
      abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t6_post_en_%0d", i), src_enable, 0);
         check($sformatf("t6_post_busy_%0d", i), busy, 0);
         check($sformatf("t6_post_done_%0d", i), done, 0);
         @(negedge clk);
      end

      // continuous single-beat bursts: burst_idx wraps after 255
      cfg_start(1, 0, 0);
      for (int i = 0; i < 260; i++) begin
         check($sformatf("t7_idx_%0d", i), burst_idx, i % 256);
         check($sformatf("t7_en_%0d", i), src_enable, 1);
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t7_abort_busy", busy, 0);

      // reset mid-burst drops enable without a clock edge
      cfg_start(2, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check("t8_pre_idx", burst_idx, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t8_rst_en", src_enable, 0);
      check("t8_rst_busy", busy, 0);
      check("t8_rst_idx", burst_idx, 0);
      @(negedge clk);
      check("t8_rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      cfg_start(2, 0, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t8_en_%0d", i), src_enable, (i < 2));
         if (i < 2) check($sformatf("t8_idx_%0d", i), burst_idx, 0);
         check($sformatf("t8_done_%0d", i), done, (i == 2));
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
